// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and defaults for the memory port arbiter
package core_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    localparam int MEM_ARB_MAX_WAIT = 15;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - response wait counter; flags timeout after MAX_WAIT idle cycles
import core_pkg::*;

module mem_arb_timer #(
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] r_count;

    // Counter is held at zero outside the wait window, so it restarts on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_en) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = i_en && (r_count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and LSU onto one memory port
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on conflict; default is LSU fixed priority.
import core_pkg::*;

module mem_port_arbiter #(
    parameter int MAX_WAIT = MEM_ARB_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic        if_err_o,
    output logic [31:0] if_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    arb_state_e  r_state;
    arb_state_e  w_state_nxt;
    arb_owner_e  r_owner;
    arb_owner_e  w_win;
    logic        w_grant;
    logic        w_timeout;
    logic        w_rvalid;
    logic        w_err;
    logic [31:0] w_rdata;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_e  r_last_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_win <= OWN_IF;
        end else if (w_grant) begin
            r_last_win <= w_win;
        end
    end

    assign w_win = (lsu_req_i && (!if_req_i || r_last_win == OWN_IF)) ? OWN_LSU : OWN_IF;
`else
    assign w_win = lsu_req_i ? OWN_LSU : OWN_IF;
`endif

    mem_arb_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == WAIT_RSP),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_rvalid    = 1'b0;
        w_err       = 1'b0;
        w_rdata     = '0;
        case (r_state)
            IDLE: begin
                if (if_req_i || lsu_req_i) begin
                    w_grant     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    w_state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                w_err   = w_timeout && !mem_rvalid_i;
                w_rdata = w_err ? 32'h0 : mem_rdata_i;
                if (mem_rvalid_i || w_timeout) begin
                    w_rvalid    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fetch requests are normalised to a full-word read when captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_win;
            if (w_win == OWN_LSU) begin
                r_we    <= lsu_we_i;
                r_be    <= lsu_be_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
            end else begin
                r_we    <= 1'b0;
                r_be    <= 4'hF;
                r_addr  <= if_addr_i;
                r_wdata <= '0;
            end
        end
    end

    // Grants are combinational on requests, so reset must mask them directly.
    assign if_gnt_o     = rst_n && w_grant && (w_win == OWN_IF);
    assign lsu_gnt_o    = rst_n && w_grant && (w_win == OWN_LSU);

    assign if_rvalid_o  = w_rvalid && (r_owner == OWN_IF);
    assign if_err_o     = w_err    && (r_owner == OWN_IF);
    assign if_rdata_o   = (r_owner == OWN_IF)  ? w_rdata : 32'h0;
    assign lsu_rvalid_o = w_rvalid && (r_owner == OWN_LSU);
    assign lsu_err_o    = w_err    && (r_owner == OWN_LSU);
    assign lsu_rdata_o  = (r_owner == OWN_LSU) ? w_rdata : 32'h0;

    assign mem_req_o    = (r_state == REQ);
    assign mem_we_o     = r_we;
    assign mem_be_o     = r_be;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench with transaction-level reference model
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [3:0]  lsu_be_i = '0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_err_o(if_err_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending requests held by the bench-side requesters.
    bit          if_pend = 0, lsu_pend = 0;
    logic [31:0] if_addr_q;
    logic        lsu_we_q;
    logic [3:0]  lsu_be_q;
    logic [31:0] lsu_addr_q, lsu_wdata_q;

    // Bus view: 0 free, 1 request presented to memory, 2 awaiting response.
    int          bus = 0;
    int          owner = 0;
    int          last_win = 0;
    int          waited = 0;
    bit          silent = 0;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;

    task automatic cycle();
        int          win;
        logic [1:0]  exp_gnt;
        logic [3:0]  exp_rsp;
        logic [31:0] exp_if_rd, exp_lsu_rd;
        bit          done, tmo;
        win = -1; exp_gnt = 2'b00; exp_rsp = 4'b0000;
        exp_if_rd = '0; exp_lsu_rd = '0; done = 0; tmo = 0;

        if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend   = 1;
            if_addr_q = $urandom;
        end
        if (!lsu_pend && $urandom_range(0, 2) == 0) begin
            lsu_pend    = 1;
            lsu_we_q    = 1'($urandom_range(0, 1));
            lsu_be_q    = 4'($urandom_range(0, 15));
            lsu_addr_q  = $urandom;
            lsu_wdata_q = $urandom;
        end
        if_req_i     = if_pend;
        if_addr_i    = if_pend ? if_addr_q : $urandom;
        lsu_req_i    = lsu_pend;
        lsu_we_i     = lsu_pend ? lsu_we_q : 1'($urandom_range(0, 1));
        lsu_be_i     = lsu_pend ? lsu_be_q : 4'($urandom_range(0, 15));
        lsu_addr_i   = lsu_pend ? lsu_addr_q : $urandom;
        lsu_wdata_i  = lsu_pend ? lsu_wdata_q : $urandom;
        mem_gnt_i    = (bus == 1) && ($urandom_range(0, 2) == 0);
        mem_rvalid_i = (bus == 2) ? (!silent && $urandom_range(0, 1) == 0)
                                  : ($urandom_range(0, 3) == 0);
        mem_rdata_i  = $urandom;
        #1;

        if (bus == 0 && (if_pend || lsu_pend)) begin
            if (if_pend && lsu_pend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = (last_win == 0) ? 1 : 0;
`else
                win = 1;
`endif
            end else begin
                win = lsu_pend ? 1 : 0;
            end
            exp_gnt = (win == 1) ? 2'b01 : 2'b10;
        end
        if (bus == 2) begin
            done = mem_rvalid_i || (waited == MAX_WAIT);
            tmo  = !mem_rvalid_i && (waited == MAX_WAIT);
            if (done) exp_rsp = (owner == 0) ? {1'b1, tmo, 2'b00} : {2'b00, 1'b1, tmo};
            if (owner == 0) exp_if_rd  = tmo ? 32'h0 : mem_rdata_i;
            else            exp_lsu_rd = tmo ? 32'h0 : mem_rdata_i;
        end

        check("gnt{if,lsu}", {30'b0, if_gnt_o, lsu_gnt_o}, {30'b0, exp_gnt});
        check("mem_req", {31'b0, mem_req_o}, {31'b0, bus == 1});
        check("rsp{if_rv,if_err,lsu_rv,lsu_err}",
              {28'b0, if_rvalid_o, if_err_o, lsu_rvalid_o, lsu_err_o}, {28'b0, exp_rsp});
        if (bus == 1) begin
            check("mem_addr", mem_addr_o, e_addr);
            check("mem_we_be", {27'b0, mem_we_o, mem_be_o}, {27'b0, e_we, e_be});
            check("mem_wdata", mem_wdata_o, e_wdata);
        end
        if (bus != 2 || owner == 1) check("if_rdata_idle", if_rdata_o, 32'h0);
        if (bus != 2 || owner == 0) check("lsu_rdata_idle", lsu_rdata_o, 32'h0);
        if (done && !(owner == 1 && e_we))
            check(owner == 0 ? "if_rdata" : "lsu_rdata",
                  owner == 0 ? if_rdata_o : lsu_rdata_o,
                  owner == 0 ? exp_if_rd : exp_lsu_rd);

        if (win >= 0) begin
            owner = win; last_win = win; bus = 1;
            silent = ($urandom_range(0, 7) == 0);
            if (win == 1) begin
                e_we = lsu_we_q; e_be = lsu_be_q; e_addr = lsu_addr_q; e_wdata = lsu_wdata_q;
                lsu_pend = 0;
            end else begin
                e_we = 1'b0; e_be = 4'hF; e_addr = if_addr_q; e_wdata = '0;
                if_pend = 0;
            end
        end else if (bus == 1 && mem_gnt_i) begin
            bus = 2; waited = 0;
        end else if (bus == 2) begin
            if (done) bus = 0;
            else waited++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {30'b0, if_gnt_o, lsu_gnt_o}, 32'h0);
        check({tag, "_mem_req"}, {31'b0, mem_req_o}, 32'h0);
        check({tag, "_rsp"}, {28'b0, if_rvalid_o, if_err_o, lsu_rvalid_o, lsu_err_o}, 32'h0);
        check({tag, "_rdata"}, if_rdata_o | lsu_rdata_o, 32'h0);
    endtask

    initial begin
        int guard;
        if_req_i  = 1'b1;
        lsu_req_i = 1'b1;
        mem_rvalid_i = 1'b1;
        #1;
        check_reset_outputs("reset");
        check("reset_mem_fields", mem_addr_o | mem_wdata_o | {27'b0, mem_we_o, mem_be_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle();
        repeat (3000) step();

        guard = 0;
        while (bus != 2 && guard < 200) begin
            step();
            guard++;
        end
        check("reach_wait_rsp", {31'b0, bus == 2}, 32'h1);
        @(negedge clk);
        if_req_i = 1'b1; lsu_req_i = 1'b1; mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus = 0; last_win = 0; owner = 0;
        cycle();
        repeat (1000) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 15, cycles in WAIT_RSP before a response timeout.
REQ-002 clock  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 if_req_i  input  1  fetch read request.
REQ-005 if_addr_i  input  32  fetch word address.
REQ-006 if_gnt_o  output  1  fetch request accepted (1-cycle pulse).
REQ-007 if_rvalid_o / if_err_o  output  1 each  fetch response valid / timeout error.
REQ-008 lsu_req_i, lsu_we_i  input  1 each  LSU request, write enable.
REQ-009 lsu_be_i  input  4  LSU byte enables.
REQ-010 lsu_addr_i, lsu_wdata_i  input  32 each  LSU address, store data.
REQ-011 lsu_gnt_o, lsu_rvalid_o, lsu_err_o  output  1 each  LSU accept pulse, response valid, timeout error.
REQ-012 if_rdata_o, lsu_rdata_o  output  32 each  read data to owner.
REQ-013 mem_req_o, mem_we_o  output  1 each  memory request, write enable.
REQ-014 mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32 each  registered request fields.
REQ-015 mem_gnt_i, mem_rvalid_i  input  1 each; mem_rdata_i  input  32  memory accept, response valid, read data.

Function
REQ-016 FSM states IDLE, REQ, WAIT_RSP shall be the only states.
REQ-017 IDLE: if any requester asserts, exactly one gnt_o pulses that cycle, request fields are registered on the edge, owner is recorded, next state REQ; otherwise stay IDLE.
REQ-018 Fetch requests shall be issued with mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-019 REQ: mem_req_o=1 with fields held stable until mem_gnt_i=1, then WAIT_RSP; mem_req_o=0 in every other state.
REQ-020 WAIT_RSP: owner's rvalid_o = mem_rvalid_i and owner's rdata_o = mem_rdata_i combinationally; on mem_rvalid_i go IDLE; non-owner rvalid_o/rdata_o stay 0.
REQ-021 Writes shall also complete on mem_rvalid_i (write acknowledge); rdata is don't-care for writes.
REQ-022 Wait counter clears on entering WAIT_RSP, increments each cycle; at MAX_WAIT with no mem_rvalid_i, owner's rvalid_o and err_o pulse together, rdata_o=0, next state IDLE.
REQ-023 mem_rvalid_i in IDLE or REQ shall be ignored.
REQ-024 Minimum transaction = 3 cycles (IDLE grant, REQ with immediate gnt, WAIT_RSP with immediate rvalid); a new grant may occur in the IDLE cycle immediately after completion.
REQ-025 Both requests in same IDLE cycle: arbitration per REQ-028; loser keeps req high and is served next.

Reset
REQ-026 reset low: state=IDLE, counter=0, owner=IF, last-winner=IF, all outputs 0, immediately and asynchronously.
REQ-027 Reset mid-transaction abandons it; no rvalid/err issued for it after release.

Configuration
REQ-028 Without MEM_ARB_ROUND_ROBIN_EN: LSU has fixed priority over fetch; with it: on conflict the requester not granted last wins, last-winner updated on every grant.

Structure
REQ-029 CORE_PKG holds arb_state_e (IDLE/REQ/WAIT_RSP), arb_owner_e (OWN_IF/OWN_LSU), and MEM_ARB_MAX_WAIT default constant.
REQ-030 One sub-module, mem_arb_timer, implements the wait counter and timeout flag; all else inline.

Verification
REQ-031 Fetch only, addr 0x100, gnt next cycle, rvalid next with 0xDEADBEEF -> if_gnt_o cycle 0, mem_req_o cycle 1, if_rvalid_o+if_rdata_o=0xDEADBEEF cycle 2.
REQ-032 Both request, fixed priority -> lsu_gnt_o first; fetch granted in IDLE after LSU completes; ROUND_ROBIN_EN build, two back-to-back conflicts -> LSU then IF.
REQ-033 LSU store addr 0x40, wdata 0x12345678, be 4'b0011, mem_gnt_i low 4 cycles -> mem_req_o and fields stable all 5 cycles.
REQ-034 No mem_rvalid_i for MAX_WAIT=15 cycles -> owner rvalid_o+err_o one pulse, rdata_o=0, FSM IDLE; later stray mem_rvalid_i ignored.
REQ-035 reset low during WAIT_RSP -> mem_req_o and all rvalid/gnt outputs 0 same cycle; after release, first grant behaves as REQ-031.
